// File: rtl/ascon_pkg.sv
// Shared types and helpers for the iterative Ascon permutation engine.
package ascon_pkg;

    localparam int MAX_ROUNDS = 12;

    // Index [0] is x0, index [4] is x4.
    typedef logic [4:0][63:0] ascon_state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ascon_fsm_e;

    function automatic logic [63:0] ascon_rc(input logic [3:0] i);
        return {56'b0, 4'hF - i, i};
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // First round index for p^a; unsupported counts fall back to p^12.
    function automatic logic [3:0] first_round(input logic [3:0] rounds);
        logic [3:0] idx;
        case (rounds)
            4'd6:    idx = 4'd6;
            4'd8:    idx = 4'd4;
            default: idx = 4'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box, linear diffusion.
module ascon_round
    import ascon_pkg::*;
(
    input  ascon_state_t state_in,
    input  logic [3:0]   rnd,
    output ascon_state_t state_out
);

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;

    always_comb begin
        x0 = state_in[0];
        x1 = state_in[1];
        x2 = state_in[2] ^ ascon_rc(rnd);
        x3 = state_in[3];
        x4 = state_in[4];

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        state_out[0] = x0 ^ rotr64(x0, 19) ^ rotr64(x0, 28);
        state_out[1] = x1 ^ rotr64(x1, 61) ^ rotr64(x1, 39);
        state_out[2] = x2 ^ rotr64(x2, 1)  ^ rotr64(x2, 6);
        state_out[3] = x3 ^ rotr64(x3, 10) ^ rotr64(x3, 17);
        state_out[4] = x4 ^ rotr64(x4, 7)  ^ rotr64(x4, 41);
    end

endmodule

// File: rtl/ascon_perm_engine.sv
// Iterative Ascon p^a core: captures the state on a start edge, runs UNROLL rounds
// per clock and strobes update/finished for one cycle when the result is ready.
module ascon_perm_engine
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [3:0]   rounds_i,
    input  ascon_state_t state_i,
    output ascon_state_t state_o,
    output logic         update_state_o,
    output logic         finished_o,
    output logic         busy_o
);

    if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
        $error("ascon_perm_engine: UNROLL must be 1 or 2");
    end

    ascon_fsm_e   fsm_reg, fsm_next;
    ascon_state_t state_reg;
    ascon_state_t round_out;
    logic [3:0]   rnd_reg;
    logic         start_q;
    logic         launch;
    logic         last_step;

    // Each stage consumes the previous stage's output with the next round index.
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
        ascon_state_t stage_in;
        ascon_state_t stage_out;
        if (gi == 0) begin : g_first
            assign stage_in = state_reg;
        end else begin : g_next
            assign stage_in = g_round[gi-1].stage_out;
        end
        ascon_round u_round (
            .state_in  (stage_in),
            .rnd       (rnd_reg + 4'(gi)),
            .state_out (stage_out)
        );
    end

    assign round_out = g_round[UNROLL-1].stage_out;

    assign launch    = start_i && !start_q && (fsm_reg == IDLE);
    assign last_step = ({1'b0, rnd_reg} + 5'(UNROLL)) >= 5'(MAX_ROUNDS);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_reg   <= IDLE;
            state_reg <= '0;
            rnd_reg   <= '0;
            start_q   <= 1'b0;
        end else begin
            start_q <= start_i;
            fsm_reg <= fsm_next;
            if (launch) begin
                state_reg <= state_i;
                rnd_reg   <= first_round(rounds_i);
            end else if (fsm_reg == RUN) begin
                state_reg <= round_out;
                rnd_reg   <= rnd_reg + 4'(UNROLL);
            end
        end
    end

    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            IDLE:    if (launch) fsm_next = RUN;
            RUN:     if (last_step) fsm_next = DONE;
            DONE:    fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    assign state_o        = state_reg;
    assign update_state_o = (fsm_reg == DONE);
    assign finished_o     = (fsm_reg == DONE);
    assign busy_o         = (fsm_reg != IDLE);

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Scoreboard bench: runs UNROLL=1 and UNROLL=2 engines side by side against a
// table-driven Ascon reference and checks result, latency and strobe count.
module tb_ascon_perm_engine;
    import ascon_pkg::*;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    typedef struct {
        ascon_state_t st;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   rounds;
    ascon_state_t state_in;
    ascon_state_t st_o [2];
    logic         upd  [2];
    logic         fin  [2];
    logic         busy [2];

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ascon_perm_engine #(.UNROLL(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rounds_i(rounds), .state_i(state_in),
        .state_o(st_o[0]), .update_state_o(upd[0]), .finished_o(fin[0]), .busy_o(busy[0]));

    ascon_perm_engine #(.UNROLL(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rounds_i(rounds), .state_i(state_in),
        .state_o(st_o[1]), .update_state_o(upd[1]), .finished_o(fin[1]), .busy_o(busy[1]));

    task automatic check(input string name, input bit ok, input logic [319:0] act,
                         input logic [319:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic int eff_rounds(input int r);
        return (r == 6 || r == 8 || r == 12) ? r : 12;
    endfunction

    // Reference permutation using the S-box lookup table column by column.
    function automatic ascon_state_t model_perm(input ascon_state_t s, input int a);
        logic [63:0] x [5];
        logic [4:0]  v, w;
        ascon_state_t res;
        for (int k = 0; k < 5; k++) x[k] = s[k];
        for (int r = 12 - a; r < 12; r++) begin
            x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
            for (int j = 0; j < 64; j++) begin
                v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                w = SBOX[v];
                x[0][j] = w[4]; x[1][j] = w[3]; x[2][j] = w[2]; x[3][j] = w[1]; x[4][j] = w[0];
            end
            x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
            x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
            x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
            x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
            x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
        end
        for (int k = 0; k < 5; k++) res[k] = x[k];
        return res;
    endfunction

    function automatic ascon_state_t rand_state();
        ascon_state_t s;
        for (int k = 0; k < 5; k++) s[k] = {$urandom(), $urandom()};
        return s;
    endfunction

    // Called at a negedge with start low and both engines idle; launch edge is the next posedge.
    task automatic launch(input ascon_state_t st, input int r);
        exp_t e;
        int   a;
        a        = eff_rounds(r);
        state_in = st;
        rounds   = 4'(r);
        start    = 1'b1;
        e.st     = model_perm(st, a);
        e.due    = cyc + 1 + a;
        q[0].push_back(e);
        e.due    = cyc + 1 + a / 2;
        q[1].push_back(e);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (q[0].size() == 0 && q[1].size() == 0 && !busy[0] && !busy[1]) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", ok, q[0].size() + q[1].size(), 0);
    endtask

    task automatic run(input ascon_state_t st, input int r);
        launch(st, r);
        @(negedge clk);
        start = 1'b0;
        drain();
    endtask

    // Monitor: every finished strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (fin[d] || upd[d])
                    check($sformatf("dut%0d_upd_eq_fin", d), fin[d] == upd[d], upd[d], fin[d]);
                if (fin[d]) begin
                    if (q[d].size() == 0) begin
                        check($sformatf("dut%0d_unexpected_finish", d), 1'b0, cyc, 0);
                    end else begin
                        e = q[d].pop_front();
                        check($sformatf("dut%0d_state", d), st_o[d] == e.st, st_o[d], e.st);
                        check($sformatf("dut%0d_latency", d), cyc == e.due, cyc, e.due);
                        $display("dut%0d result at cycle %0d: %h", d, cyc, st_o[d]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b [2];
        ascon_state_t s;
        rst      = 1'b1;
        start    = 1'b0;
        rounds   = 4'd12;
        state_in = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d_reset_state", d), st_o[d] == '0, st_o[d], 0);
            check($sformatf("dut%0d_reset_flags", d), {busy[d], fin[d], upd[d]} == 3'b000,
                  {busy[d], fin[d], upd[d]}, 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Zero state, p12, with busy duration
        launch('0, 12);
        b = '{0, 0};
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            for (int d = 0; d < 2; d++) if (busy[d]) b[d]++;
        end
        check("dut0_busy_cycles", b[0] == 13, b[0], 13);
        check("dut1_busy_cycles", b[1] == 7, b[1], 7);
        drain();

        // Random states across all legal round counts
        for (int i = 0; i < 18; i++) begin
            run(rand_state(), (i % 3 == 0) ? 6 : (i % 3 == 1) ? 8 : 12);
        end

        // Illegal round count falls back to p12
        run(rand_state(), 5);
        run(rand_state(), 0);

        // Second edge and input changes while running are ignored
        launch(rand_state(), 8);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        state_in = rand_state();
        rounds   = 4'd12;
        drain();
        repeat (20) @(negedge clk);
        start = 1'b0;
        @(negedge clk);

        // Held start launches once; a fresh edge uses the current state_i
        launch(rand_state(), 12);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 20) state_in = rand_state();
        end
        start = 1'b0;
        drain();
        @(negedge clk);
        run(rand_state(), 6);

        // Reset in the middle of a p12 run
        s = rand_state();
        launch(s, 12);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d_midrun_reset_state", d), st_o[d] == '0, st_o[d], 0);
            check($sformatf("dut%0d_midrun_reset_flags", d), {busy[d], fin[d], upd[d]} == 3'b000,
                  {busy[d], fin[d], upd[d]}, 0);
        end
        q[0].delete();
        q[1].delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        for (int d = 0; d < 2; d++)
            check($sformatf("dut%0d_idle_after_reset", d), !busy[d], busy[d], 0);
        run(s, 12);

        repeat (20) @(negedge clk);
        check("no_pending", q[0].size() + q[1].size() == 0, q[0].size() + q[1].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
